conf_bus_master: RTL
====================

// Module: conf_bus_master
// PURPOSE
//  Configuration-bus initiator for the global controller, in the conf_clk domain.
//  Accepts a stream of {select ID, data} entries and drives them onto conf_bus/sel
//  one at a time. Waits for the addressed target's conf_ack, e.g. the clock generator
//  at ID 3'b001 (div_reg load).
//  Reports done/error so the host can release the array once every target is configured.
// PARAMETERS
//  DATA_WIDTH    8   width of conf_bus and cfg_data
//  SELECT_WIDTH  3   width of sel; ID 0 is reserved as the idle value
//  NUM_TARGETS   7   number of targets, IDs 1..NUM_TARGETS; must be <= 2**SELECT_WIDTH-1
//  TIMEOUT       16  WAIT cycles allowed for an ack before error; must be >= 1
// PORTS
//  conf_clk   in   1             sole clock
//  reset      in   1             synchronous, active-high
//  start      in   1             pulse; begins a session from IDLE, DONE or ERR
//  cfg_valid  in   1             entry available
//  cfg_ready  out  1             entry accepted on cfg_valid&cfg_ready
//  cfg_sel    in   SELECT_WIDTH  target ID of the entry
//  cfg_data   in   DATA_WIDTH    payload of the entry
//  cfg_last   in   1             final entry of the session
//  conf_bus   out  DATA_WIDTH    configuration data to targets
//  sel        out  SELECT_WIDTH  target select; 0 = no target addressed
//  conf_ack   in   NUM_TARGETS   bit i = ack of target ID i+1 (sticky high until reset)
//  busy       out  1             high in LOAD or WAIT
//  done       out  1             high in DONE
//  error      out  1             high in ERR
//  err_code   out  2             0 none, 1 bad select, 2 target already acked, 3 timeout
//  cfg_count  out  SELECT_WIDTH+1  entries completed in the current session
// BEHAVIOUR
//  Clocking: single clock conf_clk. Reset is synchronous and active-high, named reset.
//  All outputs are registered except cfg_ready, which is high exactly in state LOAD.
//  Reset values: state IDLE; sel=0, conf_bus=0, busy=0, done=0, error=0, err_code=0, cfg_count=0, timer=0.
//  IDLE: start -> LOAD; clear cfg_count and err_code.
//  LOAD: on a cfg_valid handshake, check in this priority order:
//   - cfg_sel==0 or cfg_sel>NUM_TARGETS -> ERR, err_code=1.
//   - conf_ack[cfg_sel-1] already high -> ERR, err_code=2.
//   - otherwise, on the same edge: sel<=cfg_sel, conf_bus<=cfg_data, latch cfg_last, timer<=0 -> WAIT.
//  WAIT: sel/conf_bus held stable.
//   - Ack at an edge (conf_ack[sel-1]==1): sel<=0, cfg_count++, then -> DONE if last was latched, else -> LOAD.
//   - No ack at an edge: timer++; when timer reaches TIMEOUT-1 without ack -> ERR, err_code=3, sel<=0.
//   - Ack and timeout at the same edge: ack wins.
//  Minimum latency per entry: handshake at edge k, sel driven from k+1. Target latches at k+1, ack visible k+2.
//   sel returns to 0 at edge k+2, so at most one entry completes every 2 cycles.
//  DONE / ERR: sel=0; state and err_code held.
//   - start -> LOAD with cfg_count=0 and err_code=0.
//   - cfg_valid is ignored (cfg_ready=0).
//  start while busy: ignored.
//  Acks for non-addressed targets: ignored.
//  Reset mid-WAIT: returns to IDLE with sel=0 next edge. The target may already have latched the data; not retried.
//  cfg_count saturates at 2**(SELECT_WIDTH+1)-1.
// STRUCTURE
//  Package gc_conf_pkg: state enum {IDLE,LOAD,WAIT,DONE,ERR}; err_code constants; SEL_IDLE=0;
//   CLKGEN_SEL=3'b001, shared with the target decoders.
//  Single module; timer and FSM inline. No sub-module needed.
// TESTING
//  1 reset; start; entry {sel=1, data=8'h05, last=1}; clock_generator model acks next cycle
//    -> sel=1/conf_bus=05 for exactly 2 cycles; done=1; cfg_count=1; sel=0 after.
//  2 three entries {2,A1},{3,B2},{1,C3, last}, cfg_valid held high -> each sel held until its ack;
//    sel shows 0 for one cycle between entries; cfg_count=3; done=1.
//  3 entry {sel=0} and, separately after a new start, {sel=7} with NUM_TARGETS=6
//    -> ERR, err_code=1; sel never leaves 0.
//  4 target 4 never acks, TIMEOUT=16 -> error=1, err_code=3 exactly 16 cycles after sel=4 first driven;
//    sel=0; next start clears the error.
//  5 second entry to sel=1 after target 1 already acked -> ERR, err_code=2; no bus drive.
//  6 reset asserted while in WAIT -> next cycle state IDLE, sel=0, busy=0;
//    ack arriving on the same edge -> cfg_count stays 0.

Source files
------------

// File: rtl/gc_conf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gc_conf_pkg
// Shared types and constants for the global-controller configuration bus.
// Revision : 1.0 - initial release
// ============================================================================
package gc_conf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } conf_state_t;

  localparam logic [1:0] ERR_CODE_NONE    = 2'd0;
  localparam logic [1:0] ERR_CODE_BAD_SEL = 2'd1;
  localparam logic [1:0] ERR_CODE_ACKED   = 2'd2;
  localparam logic [1:0] ERR_CODE_TIMEOUT = 2'd3;

  // Select value that addresses no target; the target decoders rely on it.
  localparam int unsigned SEL_IDLE   = 0;
  localparam logic [2:0]  CLKGEN_SEL = 3'b001;

endpackage
`default_nettype wire

// File: rtl/conf_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : conf_bus_master
// Configuration-bus initiator: drives {sel, data} entries one at a time and
// waits for the addressed target's sticky ack before issuing the next.
// Revision : 1.0 - initial release
// ============================================================================
module conf_bus_master
  import gc_conf_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int SELECT_WIDTH = 3,
  parameter int NUM_TARGETS  = 7,
  parameter int TIMEOUT      = 16
) (
  input  logic                    conf_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [SELECT_WIDTH-1:0] cfg_sel,
  input  logic [DATA_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_last,
  output logic [DATA_WIDTH-1:0]   conf_bus,
  output logic [SELECT_WIDTH-1:0] sel,
  input  logic [NUM_TARGETS-1:0]  conf_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [SELECT_WIDTH:0]   cfg_count
);

  localparam int                    ID_SPACE   = 1 << SELECT_WIDTH;
  localparam int                    TIMER_W    = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [SELECT_WIDTH:0] MAX_SEL    = (SELECT_WIDTH + 1)'(NUM_TARGETS);
  localparam logic [SELECT_WIDTH-1:0] SEL_NONE = SELECT_WIDTH'(SEL_IDLE);

  conf_state_t             r_state;
  conf_state_t             w_state_nxt;

  logic [SELECT_WIDTH-1:0] r_sel;
  logic [DATA_WIDTH-1:0]   r_bus;
  logic                    r_last;
  logic [TIMER_W-1:0]      r_timer;
  logic [SELECT_WIDTH:0]   r_count;
  logic [1:0]              r_err_code;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;

  logic [SELECT_WIDTH-1:0] w_sel_nxt;
  logic [DATA_WIDTH-1:0]   w_bus_nxt;
  logic                    w_last_nxt;
  logic [TIMER_W-1:0]      w_timer_nxt;
  logic [SELECT_WIDTH:0]   w_count_nxt;
  logic [1:0]              w_err_code_nxt;

  logic [ID_SPACE-1:0]     w_ack_by_id;
  logic                    w_sel_bad;
  logic                    w_sel_acked;
  logic                    w_wait_ack;
  logic                    w_timeout;

  // Acks re-indexed by target ID so any select value indexes in range; ID 0 never acks.
  always_comb begin
    w_ack_by_id                = '0;
    w_ack_by_id[NUM_TARGETS:1] = conf_ack;
  end

  assign w_sel_bad   = (cfg_sel == SEL_NONE) || ({1'b0, cfg_sel} > MAX_SEL);
  assign w_sel_acked = w_ack_by_id[cfg_sel];
  assign w_wait_ack  = w_ack_by_id[r_sel];
  assign w_timeout   = (r_timer == TIMER_LAST);

  always_ff @(posedge conf_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (cfg_valid) begin
          if (w_sel_bad || w_sel_acked) w_state_nxt = ERR;
          else                          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // An ack seen on the final timer cycle still completes the entry.
        if (w_wait_ack)     w_state_nxt = r_last ? DONE : LOAD;
        else if (w_timeout) w_state_nxt = ERR;
      end
      DONE, ERR: begin
        if (start) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt      = r_sel;
    w_bus_nxt      = r_bus;
    w_last_nxt     = r_last;
    w_timer_nxt    = r_timer;
    w_count_nxt    = r_count;
    w_err_code_nxt = r_err_code;
    case (r_state)
      IDLE, DONE, ERR: begin
        w_sel_nxt = SEL_NONE;
        if (start) begin
          w_count_nxt    = '0;
          w_err_code_nxt = ERR_CODE_NONE;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          if (w_sel_bad) begin
            w_err_code_nxt = ERR_CODE_BAD_SEL;
          end else if (w_sel_acked) begin
            w_err_code_nxt = ERR_CODE_ACKED;
          end else begin
            w_sel_nxt   = cfg_sel;
            w_bus_nxt   = cfg_data;
            w_last_nxt  = cfg_last;
            w_timer_nxt = '0;
          end
        end
      end
      WAIT: begin
        if (w_wait_ack) begin
          w_sel_nxt = SEL_NONE;
          if (r_count != '1) w_count_nxt = r_count + 1'b1;
        end else if (w_timeout) begin
          w_sel_nxt      = SEL_NONE;
          w_err_code_nxt = ERR_CODE_TIMEOUT;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_sel_nxt = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge conf_clk) begin
    if (reset) begin
      r_sel      <= '0;
      r_bus      <= '0;
      r_last     <= 1'b0;
      r_timer    <= '0;
      r_count    <= '0;
      r_err_code <= ERR_CODE_NONE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_sel      <= w_sel_nxt;
      r_bus      <= w_bus_nxt;
      r_last     <= w_last_nxt;
      r_timer    <= w_timer_nxt;
      r_count    <= w_count_nxt;
      r_err_code <= w_err_code_nxt;
      r_busy     <= (w_state_nxt == LOAD) || (w_state_nxt == WAIT);
      r_done     <= (w_state_nxt == DONE);
      r_error    <= (w_state_nxt == ERR);
    end
  end

  assign cfg_ready = (r_state == LOAD);
  assign conf_bus  = r_bus;
  assign sel       = r_sel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign cfg_count = r_count;

endmodule
`default_nettype wire
